udma_hyper_txn_sched: RTL

- Transaction scheduler in front of the uDMA HyperBus controller.
- Shares the single HyperBus channel between NB_REQ requesters (e.g. CPU config path, auto-refresh engine, cluster DMA).
- Round-robin arbitration; one transaction in flight; latches the winner's descriptor and presents it to the controller with a valid/ready handshake.
- Waits for the controller end-of-transfer, then returns a per-requester done/error pulse and read- or write-tagged EOT events. A programmable watchdog aborts hung transfers.

---
 rtl/udma_hyper_txn_sched.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/udma_hyper_txn_sched.sv
// Round-robin transaction scheduler sharing one HyperBus channel between NB_REQ requesters,
// with one transaction in flight and a programmable watchdog for hung transfers.
module udma_hyper_txn_sched #(
    parameter int unsigned NB_REQ = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned SIZE_W = 20,
    parameter int unsigned TO_W   = 16
) (
    input  logic                       sys_clk_i,
    input  logic                       rstn_i,
    input  logic [NB_REQ-1:0]          req_valid_i,
    output logic [NB_REQ-1:0]          req_ready_o,
    input  logic [NB_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NB_REQ*SIZE_W-1:0]   req_size_i,
    input  logic [NB_REQ-1:0]          req_rwn_i,
    input  logic [NB_REQ-1:0]          req_cs_i,
    output logic [NB_REQ-1:0]          done_o,
    output logic [NB_REQ-1:0]          err_o,
    output logic                       txn_valid_o,
    input  logic                       txn_ready_i,
    output logic [ADDR_W-1:0]          txn_addr_o,
    output logic [SIZE_W-1:0]          txn_size_o,
    output logic                       txn_rwn_o,
    output logic                       txn_cs_o,
    input  logic                       eot_i,
    output logic                       abort_o,
    input  logic [TO_W-1:0]            timeout_cfg_i,
    output logic                       evt_rd_eot_o,
    output logic                       evt_wr_eot_o,
    output logic                       busy_o,
    output logic [$clog2(NB_REQ)-1:0]  grant_id_o
);

    localparam int unsigned ID_W = $clog2(NB_REQ);
    localparam int unsigned IW   = ID_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, grant_q, winner_c;
    logic [IW-1:0]     idx_sum;
    logic              any_valid_c;
    logic              sel_zero_c;
    logic              accept_c, handshake_c, expire_c;
    logic [ADDR_W-1:0] addr_q;
    logic [SIZE_W-1:0] size_q;
    logic              rwn_q, cs_q, err_q, to_q;
    logic [TO_W-1:0]   wd_q;
    logic [NB_REQ-1:0] owner_oh;

    // First pending requester at or above rr_ptr, wrapping around
    always_comb begin
        winner_c    = rr_ptr_q;
        any_valid_c = 1'b0;
        idx_sum     = '0;
        for (int i = 0; i < int'(NB_REQ); i++) begin
            idx_sum = {1'b0, rr_ptr_q} + IW'(i);
            if (idx_sum >= IW'(NB_REQ)) idx_sum = idx_sum - IW'(NB_REQ);
            if (!any_valid_c && req_valid_i[idx_sum[ID_W-1:0]]) begin
                winner_c    = idx_sum[ID_W-1:0];
                any_valid_c = 1'b1;
            end
        end
    end

    assign sel_zero_c = (req_size_i[32'(winner_c)*SIZE_W +: SIZE_W] == '0);

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state; accept is combinational so a request is taken in the cycle it appears
    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        accept_c    = 1'b0;
        handshake_c = 1'b0;
        expire_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_valid_c) begin
                    req_ready_o[winner_c] = 1'b1;
                    accept_c              = 1'b1;
                    state_d               = sel_zero_c ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (txn_ready_i) begin
                    handshake_c = 1'b1;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (eot_i) begin
                    state_d = ST_DONE;
                end else if (timeout_cfg_i != '0 && wd_q >= timeout_cfg_i - TO_W'(1)) begin
                    expire_c = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Descriptor latch, watchdog, completion flags and round-robin pointer
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            addr_q   <= '0;
            size_q   <= '0;
            rwn_q    <= 1'b0;
            cs_q     <= 1'b0;
            grant_q  <= '0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
            wd_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            if (accept_c) begin
                addr_q  <= req_addr_i[32'(winner_c)*ADDR_W +: ADDR_W];
                size_q  <= req_size_i[32'(winner_c)*SIZE_W +: SIZE_W];
                rwn_q   <= req_rwn_i[winner_c];
                cs_q    <= req_cs_i[winner_c];
                grant_q <= winner_c;
                err_q   <= sel_zero_c;
                to_q    <= 1'b0;
            end
            if (handshake_c)
                wd_q <= '0;
            else if (state_q == ST_WAIT && timeout_cfg_i != '0)
                wd_q <= wd_q + TO_W'(1);
            if (expire_c) begin
                err_q <= 1'b1;
                to_q  <= 1'b1;
            end
            if (state_q == ST_DONE)
                rr_ptr_q <= (grant_q == ID_W'(NB_REQ - 1)) ? '0 : grant_q + ID_W'(1);
        end
    end

    assign owner_oh     = NB_REQ'(1) << grant_q;
    assign txn_valid_o  = (state_q == ST_ISSUE);
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE && !err_q) ? owner_oh : '0;
    assign err_o        = (state_q == ST_DONE &&  err_q) ? owner_oh : '0;
    assign abort_o      = (state_q == ST_DONE) && to_q;
    assign evt_rd_eot_o = (state_q == ST_DONE) && !err_q &&  rwn_q;
    assign evt_wr_eot_o = (state_q == ST_DONE) && !err_q && !rwn_q;
    assign txn_addr_o   = addr_q;
    assign txn_size_o   = size_q;
    assign txn_rwn_o    = rwn_q;
    assign txn_cs_o     = cs_q;
    assign grant_id_o   = grant_q;

endmodule
